// File: rtl/mem_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: EX->WB memory-access stage with req/ack data-memory transactions and load/store lane steering.
// Optional MEM_ALIGN_CHECK_EN: misaligned LH/LHU/SH/LW/SW retire with exc_align instead of accessing memory.
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_EX,
    input  logic [3:0]         mem_op_EX,
    input  logic [DATA_W-1:0]  data_out_EX,
    input  logic [DATA_W-1:0]  rdata_2_EX,
    input  logic [RADDR_W-1:0] target_EX,
    input  logic               we_reg_EX,
    input  logic               we_hi,
    input  logic               we_lo,
    input  logic [DATA_W-1:0]  hi_EX,
    input  logic [DATA_W-1:0]  lo_EX,
    mem_stage_if.master        mem,
    output logic               stall_MEM,
    output logic               valid_MEM,
    output logic [DATA_W-1:0]  data_out_MEM,
    output logic [RADDR_W-1:0] target_MEM,
    output logic               we_reg_MEM,
    output logic               we_hi_MEM,
    output logic               we_lo_MEM,
    output logic [DATA_W-1:0]  hi_MEM,
    output logic [DATA_W-1:0]  lo_MEM,
    output logic               exc_align
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    state_t             state_reg;
    logic [3:0]         op_reg;
    logic [DATA_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [3:0]         be_reg;
    logic               mem_we_reg;
    logic               mem_req_reg;
    logic               stall_reg;

    // Control captured at request time, released on retire.
    logic [RADDR_W-1:0] target_cap_reg;
    logic               we_reg_cap_reg;
    logic               we_hi_cap_reg;
    logic               we_lo_cap_reg;
    logic [DATA_W-1:0]  hi_cap_reg;
    logic [DATA_W-1:0]  lo_cap_reg;

    logic               valid_reg;
    logic [DATA_W-1:0]  data_out_reg;
    logic [RADDR_W-1:0] target_reg;
    logic               we_reg_reg;
    logic               we_hi_reg;
    logic               we_lo_reg;
    logic [DATA_W-1:0]  hi_reg;
    logic [DATA_W-1:0]  lo_reg;

    logic               is_load_ex;
    logic               is_store_ex;
    logic               align_fault;
    logic [DATA_W-1:0]  wdata_next;
    logic [3:0]         be_next;
    logic [3:0]         sb_be;
    logic [DATA_W-1:0]  sb_wdata;
    logic [DATA_W-1:0]  sh_wdata;
    logic [7:0]         rd_byte [4];
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [DATA_W-1:0]  load_result;

    assign is_load_ex  = (mem_op_EX >= OP_LB) && (mem_op_EX <= OP_LW);
    assign is_store_ex = (mem_op_EX >= OP_SB) && (mem_op_EX <= OP_SW);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign sb_be[gi]           = (data_out_EX[1:0] == 2'(gi));
            assign sb_wdata[8*gi +: 8] = rdata_2_EX[7:0];
            assign sh_wdata[8*gi +: 8] = rdata_2_EX[8*(gi%2) +: 8];
            assign rd_byte[gi]         = mem.mem_rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        wdata_next = rdata_2_EX;
        be_next    = 4'hF;
        case (mem_op_EX)
            OP_SB: begin
                wdata_next = sb_wdata;
                be_next    = sb_be;
            end
            OP_SH: begin
                wdata_next = sh_wdata;
                be_next    = data_out_EX[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Lane selection uses the captured address so rdata is steered in the ack cycle.
    assign ld_byte = rd_byte[addr_reg[1:0]];
    assign ld_half = addr_reg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    always_comb begin
        load_result = mem.mem_rdata;
        case (op_reg)
            OP_LB:   load_result = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            OP_LBU:  load_result = {{(DATA_W-8){1'b0}}, ld_byte};
            OP_LH:   load_result = {{(DATA_W-16){ld_half[15]}}, ld_half};
            OP_LHU:  load_result = {{(DATA_W-16){1'b0}}, ld_half};
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic exc_reg;

    assign align_fault =
        (((mem_op_EX == OP_LH) || (mem_op_EX == OP_LHU) || (mem_op_EX == OP_SH)) && data_out_EX[0]) ||
        (((mem_op_EX == OP_LW) || (mem_op_EX == OP_SW)) && (data_out_EX[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (!rst) begin
            exc_reg <= 1'b0;
        end else begin
            exc_reg <= (state_reg == IDLE) && valid_EX && align_fault;
        end
    end

    assign exc_align = exc_reg;
`else
    assign align_fault = 1'b0;
    assign exc_align   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            op_reg         <= 4'd0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            be_reg         <= 4'd0;
            mem_we_reg     <= 1'b0;
            mem_req_reg    <= 1'b0;
            stall_reg      <= 1'b0;
            target_cap_reg <= '0;
            we_reg_cap_reg <= 1'b0;
            we_hi_cap_reg  <= 1'b0;
            we_lo_cap_reg  <= 1'b0;
            hi_cap_reg     <= '0;
            lo_cap_reg     <= '0;
            valid_reg      <= 1'b0;
            data_out_reg   <= '0;
            target_reg     <= '0;
            we_reg_reg     <= 1'b0;
            we_hi_reg      <= 1'b0;
            we_lo_reg      <= 1'b0;
            hi_reg         <= '0;
            lo_reg         <= '0;
        end else begin
            // Write enables are only ever high together with the valid pulse.
            valid_reg  <= 1'b0;
            we_reg_reg <= 1'b0;
            we_hi_reg  <= 1'b0;
            we_lo_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (valid_EX) begin
                        if ((is_load_ex || is_store_ex) && !align_fault) begin
                            state_reg      <= BUSY;
                            op_reg         <= mem_op_EX;
                            addr_reg       <= data_out_EX;
                            wdata_reg      <= wdata_next;
                            be_reg         <= be_next;
                            mem_we_reg     <= is_store_ex;
                            mem_req_reg    <= 1'b1;
                            stall_reg      <= 1'b1;
                            target_cap_reg <= target_EX;
                            we_reg_cap_reg <= we_reg_EX && is_load_ex;
                            we_hi_cap_reg  <= we_hi;
                            we_lo_cap_reg  <= we_lo;
                            hi_cap_reg     <= hi_EX;
                            lo_cap_reg     <= lo_EX;
                        end else begin
                            valid_reg    <= 1'b1;
                            data_out_reg <= data_out_EX;
                            target_reg   <= target_EX;
                            we_reg_reg   <= we_reg_EX && !align_fault;
                            we_hi_reg    <= we_hi;
                            we_lo_reg    <= we_lo;
                            hi_reg       <= hi_EX;
                            lo_reg       <= lo_EX;
                        end
                    end
                end
                BUSY: begin
                    if (mem.mem_ack) begin
                        state_reg    <= IDLE;
                        mem_req_reg  <= 1'b0;
                        stall_reg    <= 1'b0;
                        valid_reg    <= 1'b1;
                        data_out_reg <= mem_we_reg ? addr_reg : load_result;
                        target_reg   <= target_cap_reg;
                        we_reg_reg   <= we_reg_cap_reg;
                        we_hi_reg    <= we_hi_cap_reg;
                        we_lo_reg    <= we_lo_cap_reg;
                        hi_reg       <= hi_cap_reg;
                        lo_reg       <= lo_cap_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = {addr_reg[DATA_W-1:2], 2'b00};
    assign mem.mem_wdata = wdata_reg;
    assign mem.mem_be    = be_reg;

    assign stall_MEM    = stall_reg;
    assign valid_MEM    = valid_reg;
    assign data_out_MEM = data_out_reg;
    assign target_MEM   = target_reg;
    assign we_reg_MEM   = we_reg_reg;
    assign we_hi_MEM    = we_hi_reg;
    assign we_lo_MEM    = we_lo_reg;
    assign hi_MEM       = hi_reg;
    assign lo_MEM       = lo_reg;

endmodule
